// File: rtl/image_pad_pkg.sv
// Shared types and constants for the image_pad stage: pixel width,
// frame counter width and the two FSM encodings.
package image_pad_pkg;

    localparam int RGB_W = 24;
    localparam int CNT_W = 12;

    typedef enum logic {
        IN_IDLE,
        IN_FILL
    } in_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_RUN
    } out_state_t;

endpackage

// File: rtl/image_pad_pixel_fifo.sv
// Single-clock pixel FIFO with registered read, synchronous flush and
// occupancy output; pointers carry one extra wrap bit.
module pixel_fifo
    import image_pad_pkg::*;
#(
    parameter int FIFO_AW = 11
) (
    input  logic               clk_vp,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [RGB_W-1:0]   wr_data,
    input  logic               rd_en,
    output logic [RGB_W-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [RGB_W-1:0] mem [DEPTH];
    logic [RGB_W-1:0] rd_data_q;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             wr_ok;
    logic             rd_ok;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign rd_data = rd_data_q;

    // Flush has priority over any write or read in the same cycle.
    assign wr_ok = wr_en && !full && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_vp) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_vp) begin
        if (wr_ok) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
        if (rd_ok) rd_data_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
    end

endmodule

// File: rtl/image_pad.sv
// Re-embeds a cropped pixel stream into a full display frame: window pixels
// come from a FIFO, everything else is filled with the border colour.
module image_pad
    import image_pad_pkg::*;
#(
    parameter logic [11:0] H_DISP  = 12'd1280,
    parameter logic [11:0] V_DISP  = 12'd720,
    parameter int          X_W     = 11,
    parameter int          Y_W     = 11,
    parameter int          FIFO_AW = 11
) (
    input  logic               clk_vp,
    input  logic               rst_n,
    input  logic               EN,
    input  logic [X_W-1:0]     START_X,
    input  logic [Y_W-1:0]     START_Y,
    input  logic [X_W-1:0]     END_X,
    input  logic [Y_W-1:0]     END_Y,
    input  logic [23:0]        BORDER_RGB,
    input  logic               vs_i,
    input  logic               de_i,
    input  logic [23:0]        rgb_i,
    input  logic               vs_t,
    input  logic               de_t,
    output logic               vs_o,
    output logic               de_o,
    output logic [23:0]        rgb_o,
    output logic               underflow,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [CNT_W-1:0] H_LAST = H_DISP - 12'd1;
    localparam logic [CNT_W-1:0] V_LAST = V_DISP - 12'd1;

    logic             vs_i_q, vs_t_q;
    logic             vs_i_rise, vs_t_rise;
    in_state_t        in_state_q, in_state_d;
    out_state_t       out_state_q, out_state_d;
    logic [CNT_W-1:0] out_x_q, out_x_d;
    logic [CNT_W-1:0] out_y_q, out_y_d;
    logic             underflow_q, underflow_d;
    logic             overflow_q, overflow_d;
    logic             vs_o_q, vs_o_d;
    logic             de_o_q, de_o_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             from_fifo_q, from_fifo_d;
    logic             in_win;
    logic             rd_req;

    logic             fifo_flush, fifo_wr, fifo_rd;
    logic             fifo_full, fifo_empty;
    logic [RGB_W-1:0] fifo_rd_data;

    assign vs_i_rise = vs_i && !vs_i_q;
    assign vs_t_rise = vs_t && !vs_t_q;

    // An inverted or zero-width range on either axis yields an empty window.
    assign in_win = (out_x_q >= CNT_W'(START_X)) && (out_x_q < CNT_W'(END_X)) &&
                    (out_y_q >= CNT_W'(START_Y)) && (out_y_q < CNT_W'(END_Y));

    assign rd_req = (out_state_q == OUT_RUN) && de_t && in_win;

    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        vs_o_d      = vs_t;
        de_o_d      = de_t;
        rgb_d       = BORDER_RGB;
        from_fifo_d = 1'b0;
        fifo_flush  = 1'b0;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;

        if (!EN) begin
            in_state_d  = IN_IDLE;
            out_state_d = OUT_IDLE;
            out_x_d     = '0;
            out_y_d     = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
            fifo_flush  = 1'b1;
            vs_o_d      = vs_i;
            de_o_d      = de_i;
            rgb_d       = rgb_i;
        end else begin
            if (vs_i_rise) begin
                fifo_flush = 1'b1;
                in_state_d = IN_FILL;
            end else if (in_state_q == IN_FILL && de_i) begin
                if (fifo_full) overflow_d = 1'b1;
                else           fifo_wr    = 1'b1;
            end

            if (rd_req) begin
                if (fifo_empty) begin
                    underflow_d = 1'b1;
                end else if (!vs_i_rise) begin
                    fifo_rd     = 1'b1;
                    from_fifo_d = 1'b1;
                end
            end

            if (out_state_q == OUT_RUN && de_t) begin
                if (out_x_q == H_LAST) begin
                    out_x_d = '0;
                    out_y_d = (out_y_q == V_LAST) ? '0 : out_y_q + 12'd1;
                end else begin
                    out_x_d = out_x_q + 12'd1;
                end
            end

            // A new display frame restarts the raster and clears the sticky flags.
            if (vs_t_rise) begin
                out_state_d = OUT_RUN;
                out_x_d     = '0;
                out_y_d     = '0;
                underflow_d = 1'b0;
                overflow_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_vp) begin
        if (!rst_n) begin
            vs_i_q      <= 1'b0;
            vs_t_q      <= 1'b0;
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            out_x_q     <= '0;
            out_y_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            vs_o_q      <= 1'b0;
            de_o_q      <= 1'b0;
            rgb_q       <= '0;
            from_fifo_q <= 1'b0;
        end else begin
            vs_i_q      <= vs_i;
            vs_t_q      <= vs_t;
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            vs_o_q      <= vs_o_d;
            de_o_q      <= de_o_d;
            rgb_q       <= rgb_d;
            from_fifo_q <= from_fifo_d;
        end
    end

    pixel_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_vp  (clk_vp),
        .rst_n   (rst_n),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (rgb_i),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The FIFO read register already lands one cycle after the pop.
    assign rgb_o     = from_fifo_q ? fifo_rd_data : rgb_q;
    assign vs_o      = vs_o_q;
    assign de_o      = de_o_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_image_pad.sv
// Randomized scoreboard bench for image_pad: a frame-level reference model
// predicts every output cycle; a negedge monitor pops and compares.
module tb_image_pad;

    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [23:0] BORDER = 24'hABCDEF;

    logic        clk_vp = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] start_x, start_y, end_x, end_y;
    logic        vs_i, de_i, vs_t, de_t;
    logic [23:0] rgb_i;
    logic        vs_o, de_o, underflow, overflow;
    logic [23:0] rgb_o;
    logic [AW:0] fifo_level;

    always #5 clk_vp = ~clk_vp;

    image_pad #(
        .H_DISP (12'd8), .V_DISP (12'd4), .X_W (11), .Y_W (11), .FIFO_AW (AW)
    ) dut (
        .clk_vp (clk_vp), .rst_n (rst_n), .EN (en),
        .START_X (start_x), .START_Y (start_y), .END_X (end_x), .END_Y (end_y),
        .BORDER_RGB (BORDER),
        .vs_i (vs_i), .de_i (de_i), .rgb_i (rgb_i),
        .vs_t (vs_t), .de_t (de_t),
        .vs_o (vs_o), .de_o (de_o), .rgb_o (rgb_o),
        .underflow (underflow), .overflow (overflow), .fifo_level (fifo_level)
    );

    typedef struct {
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic        uf;
        logic        ov;
        int          level;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: window position is derived from a running pixel index.
    logic [23:0] m_fifo[$];
    bit m_vi_prev, m_vt_prev, m_fill, m_run, m_uf, m_ov;
    int m_p;

    task automatic cyc();
        exp_t e;
        bit rise_i, rise_t, win, want, set_uf, set_ov;
        int sz, x, y;
        e.vs = 1'b0; e.de = 1'b0; e.rgb = '0;
        if (!rst_n) begin
            m_fifo.delete();
            m_fill = 0; m_run = 0; m_uf = 0; m_ov = 0; m_p = 0;
        end else if (!en) begin
            e.vs = vs_i; e.de = de_i; e.rgb = rgb_i;
            m_fifo.delete();
            m_fill = 0; m_run = 0; m_uf = 0; m_ov = 0; m_p = 0;
        end else begin
            rise_i = vs_i && !m_vi_prev;
            rise_t = vs_t && !m_vt_prev;
            sz = m_fifo.size();
            x = m_p % H;
            y = (m_p / H) % V;
            win = (x >= int'(start_x)) && (x < int'(end_x)) &&
                  (y >= int'(start_y)) && (y < int'(end_y));
            want = m_run && de_t && win;
            set_uf = want && (sz == 0);
            set_ov = 0;
            e.rgb = BORDER;
            if (rise_i) begin
                m_fifo.delete();
                m_fill = 1;
            end else begin
                if (want && sz > 0) e.rgb = m_fifo.pop_front();
                if (m_fill && de_i) begin
                    if (sz == DEPTH) set_ov = 1;
                    else m_fifo.push_back(rgb_i);
                end
            end
            if (rise_t) begin
                m_uf = 0; m_ov = 0; m_run = 1; m_p = 0;
            end else begin
                m_uf = m_uf | set_uf;
                m_ov = m_ov | set_ov;
                if (m_run && de_t) m_p = (m_p + 1) % (H * V);
            end
            e.vs = vs_t; e.de = de_t;
        end
        e.uf = m_uf; e.ov = m_ov; e.level = m_fifo.size();
        if (!rst_n) begin
            m_vi_prev = 0; m_vt_prev = 0;
        end else begin
            m_vi_prev = vs_i; m_vt_prev = vs_t;
        end
        @(posedge clk_vp);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic chk(string name, int act, int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk_vp) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("vs_o", int'(vs_o), int'(e.vs));
            chk("de_o", int'(de_o), int'(e.de));
            chk("rgb_o", int'(rgb_o), int'(e.rgb));
            chk("underflow", int'(underflow), int'(e.uf));
            chk("overflow", int'(overflow), int'(e.ov));
            chk("fifo_level", int'(fifo_level), e.level);
            if (e.de)
                $display("pix t=%0t rgb=%06h uf=%0d ov=%0d lvl=%0d",
                         $time, rgb_o, underflow, overflow, fifo_level);
        end
    end

    task automatic idle_inputs();
        vs_i = 0; de_i = 0; rgb_i = '0; vs_t = 0; de_t = 0;
    endtask

    task automatic in_frame(int n, bit seq);
        vs_i = 1; cyc();
        vs_i = 0; cyc();
        for (int k = 0; k < n; k++) begin
            de_i = 1;
            rgb_i = seq ? 24'(k + 1) : 24'($urandom);
            cyc();
            de_i = 0;
            if (!seq) repeat ($urandom_range(0, 1)) cyc();
        end
        de_i = 0; cyc();
    endtask

    task automatic out_frame(bit traffic, bit gaps);
        vs_t = 1; cyc();
        vs_t = 0; cyc();
        for (int ly = 0; ly < V; ly++) begin
            for (int lx = 0; lx < H; lx++) begin
                de_t = 1;
                de_i = traffic && ($urandom_range(0, 2) == 0);
                rgb_i = 24'($urandom);
                cyc();
                de_t = 0; de_i = 0;
                if (gaps) repeat ($urandom_range(0, 2)) cyc();
            end
            de_t = 0; cyc(); cyc();
        end
    endtask

    task automatic set_win(int sx, int ex, int sy, int ey);
        start_x = 11'(sx); end_x = 11'(ex); start_y = 11'(sy); end_y = 11'(ey);
    endtask

    initial begin
        idle_inputs();
        en = 1; rst_n = 0;
        set_win(2, 5, 1, 3);
        repeat (3) cyc();
        rst_n = 1; cyc();

        // Directed window, exact fill, then short fill with underflow.
        in_frame(6, 1);
        out_frame(0, 0);
        in_frame(2, 1);
        out_frame(0, 1);
        vs_t = 1; cyc(); vs_t = 0; cyc();

        // Overflow: 17 writes into a 16-deep FIFO, then drain through a full window.
        in_frame(17, 1);
        set_win(0, 8, 0, 4);
        out_frame(0, 0);

        // Reset in the middle of a frame.
        in_frame(5, 1);
        vs_t = 1; cyc(); vs_t = 0;
        de_t = 1; repeat (3) cyc();
        rst_n = 0; repeat (2) cyc();
        rst_n = 1; de_t = 0; cyc();

        // Bypass mode.
        en = 0;
        vs_i = 1; de_i = 1; rgb_i = 24'h123456; cyc();
        for (int k = 0; k < 12; k++) begin
            vs_i = 1'($urandom); de_i = 1'($urandom); rgb_i = 24'($urandom);
            cyc();
        end
        idle_inputs(); cyc();
        en = 1; cyc();

        // Empty window keeps the FIFO untouched; a new input frame flushes it.
        set_win(3, 3, 0, 4);
        in_frame(4, 1);
        out_frame(0, 1);
        vs_i = 1; cyc(); vs_i = 0; cyc();

        // Randomized windows, fill counts and concurrent traffic.
        for (int it = 0; it < 12; it++) begin
            set_win($urandom_range(0, 7), $urandom_range(0, 8),
                    $urandom_range(0, 3), $urandom_range(0, 4));
            in_frame($urandom_range(0, 20), 0);
            out_frame(1'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin
                en = 0;
                repeat ($urandom_range(1, 4)) begin
                    de_i = 1'($urandom); rgb_i = 24'($urandom); cyc();
                end
                idle_inputs(); en = 1; cyc();
            end
        end

        idle_inputs();
        repeat (3) cyc();
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_vp);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_pad.md
Name: image_pad

Overview:
Inverse of the crop stage in the DVP video path. Accepts a cropped window pixel stream (vs_i/de_i/rgb_i) and buffers it in a pixel FIFO. Re-embeds the window at START_X/START_Y inside a full H_DISP x V_DISP frame, whose timing comes from the display timing (vs_t/de_t). Pixels outside the window are filled with BORDER_RGB. Both streams are synchronous to clk_vp.

Parameters:
H_DISP, 12'd1280, active pixels per line of output frame
V_DISP, 12'd720, active lines per output frame
X_W, 11, width of START_X/END_X
Y_W, 11, width of START_Y/END_Y
FIFO_AW, 11, FIFO address width; depth = 2**FIFO_AW (power of two)

Ports:
clk_vp  in  1  video clock, all logic
rst_n  in  1  synchronous active-low reset
EN  in  1  1 = pad mode, 0 = registered bypass of input stream
START_X  in  X_W  first window column (inclusive)
START_Y  in  Y_W  first window line (inclusive)
END_X  in  X_W  window column end (exclusive)
END_Y  in  Y_W  window line end (exclusive)
BORDER_RGB  in  24  fill colour outside window / on underflow
vs_i  in  1  input (cropped) frame sync, rising edge = new frame
de_i  in  1  input pixel valid
rgb_i  in  24  input pixel
vs_t  in  1  output timing frame sync, rising edge = new frame
de_t  in  1  output timing active pixel
vs_o  out  1  output frame sync
de_o  out  1  output data enable
rgb_o  out  24  output pixel
underflow  out  1  sticky: window pixel requested with FIFO empty
overflow  out  1  sticky: input pixel dropped, FIFO full
fifo_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at clk_vp edge): vs_o=de_o=0, rgb_o=0, underflow=overflow=0, FIFO emptied (level 0), counters 0, both FSMs to idle.
- Edge detect: vs_i and vs_t each registered once; rise = cur & ~prev.
- Input FSM: IN_IDLE -> IN_FILL on vs_i rise. In IN_FILL, de_i & ~full writes rgb_i; de_i & full drops the pixel and sets overflow. de_i in IN_IDLE is ignored. Every vs_i rise flushes the FIFO (level->0), and the flush beats any write/read in that cycle.
- Output FSM: OUT_IDLE -> OUT_RUN on vs_t rise. A vs_t rise in any state zeroes out_x/out_y and clears underflow/overflow.
- Counters (OUT_RUN): out_x increments on de_t and wraps to 0 at H_DISP-1. out_y increments when out_x wraps and wraps to 0 at V_DISP-1. Widths are 12 bits.
- in_win = out_x>=START_X & out_x<END_X & out_y>=START_Y & out_y<END_Y, using unsigned compares. If START>=END on either axis, the window is empty: all BORDER, no reads.
- Read: de_t & in_win & ~empty & OUT_RUN pops one word. FIFO read is synchronous, so data is valid the next cycle.
- Latency: exactly 1 cycle. vs_o<=vs_t and de_o<=de_t. rgb_o<=FIFO data if a pop occurred last cycle, else BORDER_RGB.
- If de_t & in_win & empty: rgb_o=BORDER_RGB next cycle and underflow=1. There is no write-to-read bypass, so a simultaneous write into an empty FIFO still counts as underflow.
- Simultaneous read+write: level unchanged. When full at the start of the cycle, the write is dropped even if a read occurs.
- In OUT_IDLE, de_o follows de_t delayed, and rgb_o=BORDER_RGB.
- EN=0: vs_o<=vs_i, de_o<=de_i, rgb_o<=rgb_i (1-cycle delay). FIFO held flushed, FSMs forced to idle, flags cleared. An EN 0->1 transition takes effect next cycle, and both FSMs wait for fresh sync rises.
- fifo_level is registered and reflects the write/read/flush of the previous cycle.

Decomposition:
- Package image_pad_pkg: RGB_W=24, input FSM encoding {IN_IDLE, IN_FILL}, output FSM encoding {OUT_IDLE, OUT_RUN}.
- Sub-module pixel_fifo: single-clock synchronous FIFO. Width RGB_W, depth 2**FIFO_AW, sync read, with flush input and full/empty/level outputs. Pointers are FIFO_AW+1 bits.

Test Plan (H_DISP=8, V_DISP=4, FIFO_AW=4, BORDER_RGB=24'hABCDEF, EN=1):
1. rst_n=0 for 2 cycles mid-frame -> vs_o=de_o=0, rgb_o=0, underflow=overflow=0, fifo_level=0.
2. Window X 2..5, Y 1..3. Pulse vs_i, write 6 pixels 1..6 (fifo_level=6), then run one vs_t frame -> row1 cols 2,3,4 = 1,2,3. Row2 = 4,5,6. All other de_o pixels = ABCDEF. Output is 1 cycle after de_t. Underflow stays 0 and fifo_level ends at 0.
3. Same window, only 2 pixels written -> row1 col4 = ABCDEF and underflow=1. The next vs_t rise clears underflow to 0.
4. vs_i then 17 writes with no reads -> fifo_level=16 and overflow=1. A later read sequence returns pixels 1..16, so the 17th was dropped.
5. EN=0 with vs_i/de_i/rgb_i=1/1/0x123456 -> vs_o/de_o/rgb_o show the same values one cycle later. fifo_level=0.
6. START_X=END_X=3 with FIFO preloaded to 4 -> whole frame ABCDEF and fifo_level stays 4. A vs_i rise then gives fifo_level=0 next cycle.
